rr_arbiter: RTL and testbench

//   Parameterised request/grant arbiter that shares one downstream resource (mux, port, bus) between

---
 rtl/rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Request/grant arbiter with round-robin or fixed priority and optional grant hold.
// Two priority encoders (masked and unmasked request) pick the next winner; grant outputs are registered.

module priority_encoder #(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]         req_in,
    output logic                     valid,
    output logic [$clog2(WIDTH)-1:0] encoded,
    output logic [WIDTH-1:0]         unencoded
);

    localparam int unsigned ENC_W = $clog2(WIDTH);

    always_comb begin
        valid   = 1'b0;
        encoded = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (LSB_HIGH_PRIORITY != 0) begin
                if (req_in[i] && !valid) begin
                    valid   = 1'b1;
                    encoded = ENC_W'(i);
                end
            end else if (req_in[i]) begin
                valid   = 1'b1;
                encoded = ENC_W'(i);
            end
        end
    end

    always_comb begin
        unencoded = '0;
        if (valid) begin
            unencoded[encoded] = 1'b1;
        end
    end

endmodule

module rr_arbiter #(
    parameter int PORTS                 = 4,
    parameter int ARB_TYPE_ROUND_ROBIN  = 1,
    parameter int ARB_BLOCK             = 1,
    parameter int ARB_BLOCK_ACK         = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded
);

    localparam int unsigned ENC_W = $clog2(PORTS);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t             state;
    logic [PORTS-1:0]   mask;
    logic [PORTS-1:0]   req_masked;

    logic               m_valid;
    logic [ENC_W-1:0]   m_enc;
    logic [PORTS-1:0]   m_onehot;
    logic               u_valid;
    logic [ENC_W-1:0]   u_enc;
    logic [PORTS-1:0]   u_onehot;

    logic               release_pt;
    logic [PORTS-1:0]   win_grant;
    logic [ENC_W-1:0]   win_enc;
    logic [PORTS-1:0]   next_mask;

    assign req_masked  = request & mask;
    assign grant_valid = (state == GRANTED);

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_masked (
        .req_in    (req_masked),
        .valid     (m_valid),
        .encoded   (m_enc),
        .unencoded (m_onehot)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_unmasked (
        .req_in    (request),
        .valid     (u_valid),
        .encoded   (u_enc),
        .unencoded (u_onehot)
    );

    // Idle is always a release point; while granted the release depends on the hold mode.
    always_comb begin
        release_pt = 1'b1;
        if (state == GRANTED && ARB_BLOCK != 0) begin
            if (ARB_BLOCK_ACK != 0) begin
                release_pt = |(grant & acknowledge);
            end else begin
                release_pt = ~|(grant & request);
            end
        end
    end

    always_comb begin
        if (ARB_TYPE_ROUND_ROBIN != 0 && m_valid) begin
            win_grant = m_onehot;
            win_enc   = m_enc;
        end else begin
            win_grant = u_onehot;
            win_enc   = u_enc;
        end
    end

    // Mask keeps only ports that come after the winner in rotation order; empty after the last one.
    always_comb begin
        next_mask = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (ARB_LSB_HIGH_PRIORITY != 0) begin
                next_mask[i] = (ENC_W'(i) > win_enc);
            end else begin
                next_mask[i] = (ENC_W'(i) < win_enc);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            grant_encoded <= '0;
            mask          <= '0;
        end else if (release_pt) begin
            if (u_valid) begin
                state         <= GRANTED;
                grant         <= win_grant;
                grant_encoded <= win_enc;
                mask          <= next_mask;
            end else begin
                state <= IDLE;
                grant <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: PORTS=4, round-robin, LSB priority, blocking with acknowledge.

module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] request;
    logic [3:0] acknowledge;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_encoded;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] g;
        logic       v;
        logic [1:0] e;
        string      tag;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ack;
        logic [3:0] g;
        logic       v;
        logic [1:0] e;
    } step_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rr_arbiter #(
        .PORTS                 (4),
        .ARB_TYPE_ROUND_ROBIN  (1),
        .ARB_BLOCK             (1),
        .ARB_BLOCK_ACK         (1),
        .ARB_LSB_HIGH_PRIORITY (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .request       (request),
        .acknowledge   (acknowledge),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_encoded (grant_encoded)
    );

    function automatic exp_t mk_exp(logic [3:0] g, logic v, logic [1:0] e, string tag);
        exp_t x;
        x.g = g; x.v = v; x.e = e; x.tag = tag;
        return x;
    endfunction

    function automatic step_t mk_step(logic [3:0] req, logic [3:0] ack, logic [3:0] g, logic v, logic [1:0] e);
        step_t s;
        s.req = req; s.ack = ack; s.g = g; s.v = v; s.e = e;
        return s;
    endfunction

    task automatic cyc(input logic [3:0] req, input logic [3:0] ack);
        @(negedge clk);
        request     = req;
        acknowledge = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        rst_n = 1'b0; request = 4'b1111; acknowledge = 4'b0000;
        #2;
        sb.push_back(mk_exp(4'b0000, 1'b0, 2'd0, "t1_reset_async"));
        e = sb.pop_front(); checks++;
        if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
            errors++;
            $display("FAIL %s: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                     e.tag, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
        end
        @(posedge clk); #1;
        sb.push_back(mk_exp(4'b0000, 1'b0, 2'd0, "t1_reset_edge"));
        e = sb.pop_front(); checks++;
        if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
            errors++;
            $display("FAIL %s: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                     e.tag, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
        end
        @(negedge clk); rst_n = 1'b1;
        sb.push_back(mk_exp(4'b0001, 1'b1, 2'd0, "t1_first_grant"));
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
            errors++;
            $display("FAIL %s: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                     e.tag, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
        end
    endtask

    task automatic test_fairness;
        step_t st[$];
        exp_t  e;
        logic [3:0] seen = 4'b0000;
        st.push_back(mk_step(4'b1111, 4'b0001, 4'b0010, 1'b1, 2'd1));
        st.push_back(mk_step(4'b1111, 4'b0010, 4'b0100, 1'b1, 2'd2));
        st.push_back(mk_step(4'b1111, 4'b0100, 4'b1000, 1'b1, 2'd3));
        st.push_back(mk_step(4'b1111, 4'b1000, 4'b0001, 1'b1, 2'd0));
        foreach (st[i]) begin
            sb.push_back(mk_exp(st[i].g, st[i].v, st[i].e, "t2_rotation"));
            cyc(st[i].req, st[i].ack);
            seen |= grant;
            e = sb.pop_front(); checks++;
            if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
                errors++;
                $display("FAIL %s[%0d]: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                         e.tag, i, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
            end
        end
        checks++;
        if (seen !== 4'b1111) begin
            errors++;
            $display("FAIL t2_all_ports_in_4: got %b, want 1111", seen);
        end
    endtask

    task automatic test_block_hold;
        step_t st[$];
        exp_t  e;
        st.push_back(mk_step(4'b1111, 4'b0001, 4'b0010, 1'b1, 2'd1));
        repeat (5) st.push_back(mk_step(4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1));
        st.push_back(mk_step(4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd1));
        st.push_back(mk_step(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1));
        foreach (st[i]) begin
            sb.push_back(mk_exp(st[i].g, st[i].v, st[i].e, "t3_block_hold"));
            cyc(st[i].req, st[i].ack);
            e = sb.pop_front(); checks++;
            if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
                errors++;
                $display("FAIL %s[%0d]: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                         e.tag, i, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
            end
        end
    endtask

    task automatic test_wrap;
        step_t st[$];
        exp_t  e;
        st.push_back(mk_step(4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3));
        st.push_back(mk_step(4'b0101, 4'b1000, 4'b0001, 1'b1, 2'd0));
        st.push_back(mk_step(4'b0101, 4'b0001, 4'b0100, 1'b1, 2'd2));
        foreach (st[i]) begin
            sb.push_back(mk_exp(st[i].g, st[i].v, st[i].e, "t4_wrap"));
            cyc(st[i].req, st[i].ack);
            e = sb.pop_front(); checks++;
            if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
                errors++;
                $display("FAIL %s[%0d]: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                         e.tag, i, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
            end
        end
    endtask

    task automatic test_stray_ack;
        step_t st[$];
        exp_t  e;
        st.push_back(mk_step(4'b0001, 4'b0100, 4'b0001, 1'b1, 2'd0));
        st.push_back(mk_step(4'b1111, 4'b1110, 4'b0001, 1'b1, 2'd0));
        st.push_back(mk_step(4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0));
        st.push_back(mk_step(4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0));
        foreach (st[i]) begin
            sb.push_back(mk_exp(st[i].g, st[i].v, st[i].e, "t5_stray_ack"));
            cyc(st[i].req, st[i].ack);
            e = sb.pop_front(); checks++;
            if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
                errors++;
                $display("FAIL %s[%0d]: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                         e.tag, i, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        sb.push_back(mk_exp(4'b0100, 1'b1, 2'd2, "t6_setup"));
        cyc(4'b0100, 4'b0001);
        e = sb.pop_front(); checks++;
        if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
            errors++;
            $display("FAIL %s: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                     e.tag, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
        end
        @(negedge clk);
        request = 4'b1010; acknowledge = 4'b0000; rst_n = 1'b0;
        #1;
        sb.push_back(mk_exp(4'b0000, 1'b0, 2'd0, "t6_async_clear"));
        e = sb.pop_front(); checks++;
        if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
            errors++;
            $display("FAIL %s: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                     e.tag, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
        end
        #1 rst_n = 1'b1;
        sb.push_back(mk_exp(4'b0010, 1'b1, 2'd1, "t6_mask_cleared"));
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
            errors++;
            $display("FAIL %s: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                     e.tag, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
        end
    endtask

    task automatic test_idle_ack;
        step_t st[$];
        exp_t  e;
        st.push_back(mk_step(4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd1));
        st.push_back(mk_step(4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd1));
        st.push_back(mk_step(4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2));
        foreach (st[i]) begin
            sb.push_back(mk_exp(st[i].g, st[i].v, st[i].e, "t7_idle_ack"));
            cyc(st[i].req, st[i].ack);
            e = sb.pop_front(); checks++;
            if ({grant, grant_valid, grant_encoded} !== {e.g, e.v, e.e}) begin
                errors++;
                $display("FAIL %s[%0d]: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                         e.tag, i, grant, grant_valid, grant_encoded, e.g, e.v, e.e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fairness();
        test_block_hold();
        test_wrap();
        test_stray_ack();
        test_async_reset();
        test_idle_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
